adc_fill_sequencer: RTL and testbench

Per-channel fill controller that sequences the ADC header/data/checksum mux feeding the DDR3 write FIFO. On each accepted trigger it drives the mux selects through header, N bursts of data, and checksum, and generates the FIFO write strobe aligned to the mux's one-cycle registered output. It owns the per-channel fill number and DDR3 burst address bookkeeping presented in the header.

---
 rtl/adc_fill_sequencer.sv | 107 ++++++++++
 tb/tb_adc_fill_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_fill_sequencer.sv
// Per-channel ADC fill sequencer: walks the header/data/checksum mux through one fill
// and strobes the DDR3 write FIFO one cycle behind each loaded mux word.
module adc_fill_sequencer #(
    parameter int ADR_W = 23,
    parameter int CNT_W = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             trig,
    input  logic [1:0]       fill_type_in,
    input  logic [CNT_W-1:0] num_bursts_in,
    input  logic             fifo_full,
    output logic             select_dat,
    output logic             select_checksum,
    output logic [1:0]       fill_type,
    output logic [CNT_W-1:0] num_fill_bursts,
    output logic [ADR_W-1:0] burst_start_adr,
    output logic [23:0]      fill_num,
    output logic             fifo_wr_en,
    output logic             busy,
    output logic             fill_done,
    output logic [15:0]      missed_trig,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, HEADER, DATA, CKSUM} state_t;

    state_t           state, state_nxt;
    logic [1:0]       phase;
    logic [CNT_W-1:0] burst_cnt;
    logic             wr_pend;
    logic             accept;
    logic             last_word;

    // The done cycle is already IDLE, but a trigger there still counts as missed.
    assign accept    = trig & enable & (state == IDLE) & ~fill_done;
    assign last_word = (phase == 2'd3) && (burst_cnt == num_fill_bursts - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = HEADER;
            HEADER:  state_nxt = (num_fill_bursts == '0) ? CKSUM : DATA;
            DATA:    if (last_word) state_nxt = CKSUM;
            CKSUM:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        select_dat      = (state == DATA);
        select_checksum = (state == CKSUM);
        busy            = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase           <= '0;
            burst_cnt       <= '0;
            wr_pend         <= 1'b0;
            fill_done       <= 1'b0;
            fill_type       <= '0;
            num_fill_bursts <= '0;
            burst_start_adr <= '0;
            fill_num        <= '0;
            missed_trig     <= '0;
            overflow        <= 1'b0;
        end else begin
            // Mux output is registered, so each strobe trails its select cycle by one.
            wr_pend   <= (state == HEADER) || (state == DATA && phase == 2'd3) || (state == CKSUM);
            fill_done <= (state == CKSUM);

            if (state == DATA) begin
                phase <= phase + 2'd1;
                if (phase == 2'd3) burst_cnt <= burst_cnt + CNT_W'(1);
            end else begin
                phase     <= '0;
                burst_cnt <= '0;
            end

            if (accept) begin
                fill_type       <= fill_type_in;
                num_fill_bursts <= num_bursts_in;
            end

            if (state == CKSUM) begin
                fill_num        <= fill_num + 24'd1;
                burst_start_adr <= burst_start_adr + ADR_W'(num_fill_bursts) + ADR_W'(2);
            end

            if (trig && (busy || fill_done) && missed_trig != 16'hFFFF)
                missed_trig <= missed_trig + 16'd1;

            if (wr_pend && fifo_full) overflow <= 1'b1;
        end
    end

    // ADC data cannot stall: a full FIFO just drops the word.
    assign fifo_wr_en = wr_pend & ~fifo_full;

endmodule

// File: tb/tb_adc_fill_sequencer.sv
// Directed bench for adc_fill_sequencer: per-cycle output vectors of each fill are
// compared against hand-derived bit patterns (bit c = cycle T+c, trigger in cycle T).
module tb_adc_fill_sequencer;

    logic        clk = 1'b0;
    logic        reset, enable, trig, fifo_full;
    logic [1:0]  fill_type_in;
    logic [20:0] num_bursts_in;
    logic        select_dat, select_checksum, fifo_wr_en, busy, fill_done, overflow;
    logic [1:0]  fill_type;
    logic [20:0] num_fill_bursts;
    logic [22:0] burst_start_adr;
    logic [23:0] fill_num;
    logic [15:0] missed_trig;

    // Narrow-address instance so the address wrap is reachable in a few fills.
    logic        trig2;
    logic [2:0]  num2;
    logic        sd2, sc2, wr2, busy2, done2, ovf2;
    logic [1:0]  ft2;
    logic [2:0]  nfb2;
    logic [3:0]  adr2;
    logic [23:0] fn2;
    logic [15:0] mt2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] wr_v, busy_v, done_v, dat_v, ck_v;

    always #5 clk = ~clk;

    adc_fill_sequencer dut (
        .clk(clk), .reset(reset), .enable(enable), .trig(trig),
        .fill_type_in(fill_type_in), .num_bursts_in(num_bursts_in), .fifo_full(fifo_full),
        .select_dat(select_dat), .select_checksum(select_checksum), .fill_type(fill_type),
        .num_fill_bursts(num_fill_bursts), .burst_start_adr(burst_start_adr), .fill_num(fill_num),
        .fifo_wr_en(fifo_wr_en), .busy(busy), .fill_done(fill_done),
        .missed_trig(missed_trig), .overflow(overflow)
    );

    adc_fill_sequencer #(.ADR_W(4), .CNT_W(3)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .trig(trig2),
        .fill_type_in(fill_type_in), .num_bursts_in(num2), .fifo_full(fifo_full),
        .select_dat(sd2), .select_checksum(sc2), .fill_type(ft2),
        .num_fill_bursts(nfb2), .burst_start_adr(adr2), .fill_num(fn2),
        .fifo_wr_en(wr2), .busy(busy2), .fill_done(done2),
        .missed_trig(mt2), .overflow(ovf2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after an edge; that cycle is T. trig is high for c <= tl,
    // fifo_full only in cycle fc, enable drops in cycle eo (-1 = never).
    task automatic capture(input logic [20:0] n, input int len, input int tl,
                           input int fc, input int eo);
        num_bursts_in = n;
        wr_v = '0; busy_v = '0; done_v = '0; dat_v = '0; ck_v = '0;
        for (int c = 0; c < len; c++) begin
            trig      = (c <= tl);
            fifo_full = (c == fc);
            if (c == eo) enable = 1'b0;
            #1;
            wr_v[c]   = fifo_wr_en;
            busy_v[c] = busy;
            done_v[c] = fill_done;
            dat_v[c]  = select_dat;
            ck_v[c]   = select_checksum;
            tick();
        end
        trig = 1'b0; fifo_full = 1'b0; enable = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; trig = 1'b0; trig2 = 1'b0; fifo_full = 1'b0;
        fill_type_in = 2'd0; num_bursts_in = '0; num2 = '0;
        tick(); tick();
        n_checks++;
        if ({select_dat, select_checksum, fifo_wr_en, busy, fill_done, overflow} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                {select_dat, select_checksum, fifo_wr_en, busy, fill_done, overflow});
        end
        n_checks++;
        if ({fill_num, burst_start_adr, missed_trig, fill_type, num_fill_bursts} !== '0) begin
            n_fail++; $display("FAIL reset_regs: fill_num %h adr %h missed %h type %h nb %h expected all 0",
                fill_num, burst_start_adr, missed_trig, fill_type, num_fill_bursts);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        fill_type_in = 2'd2;
        capture(21'd2, 14, 0, -1, -1);
        fill_type_in = 2'd1;
        n_checks++;
        if (wr_v !== 32'h0000_0C44) begin n_fail++; $display("FAIL basic_wr: got %h expected %h", wr_v, 32'h0C44); end
        n_checks++;
        if (busy_v !== 32'h0000_07FE) begin n_fail++; $display("FAIL basic_busy: got %h expected %h", busy_v, 32'h07FE); end
        n_checks++;
        if (done_v !== 32'h0000_0800) begin n_fail++; $display("FAIL basic_done: got %h expected %h", done_v, 32'h0800); end
        n_checks++;
        if (dat_v !== 32'h0000_03FC) begin n_fail++; $display("FAIL basic_sel_dat: got %h expected %h", dat_v, 32'h03FC); end
        n_checks++;
        if (ck_v !== 32'h0000_0400) begin n_fail++; $display("FAIL basic_sel_ck: got %h expected %h", ck_v, 32'h0400); end
        n_checks++;
        if (fill_num !== 24'd1 || burst_start_adr !== 23'd4) begin
            n_fail++; $display("FAIL basic_book: fill_num %0d adr %0d expected 1 4", fill_num, burst_start_adr);
        end
        n_checks++;
        if (fill_type !== 2'd2 || num_fill_bursts !== 21'd2) begin
            n_fail++; $display("FAIL basic_hdr: type %0d nb %0d expected 2 2", fill_type, num_fill_bursts);
        end
    endtask

    task automatic test_zero_bursts;
        capture(21'd0, 6, 0, -1, -1);
        n_checks++;
        if (wr_v !== 32'h0000_000C) begin n_fail++; $display("FAIL zero_wr: got %h expected %h", wr_v, 32'h0C); end
        n_checks++;
        if (busy_v !== 32'h6 || done_v !== 32'h8 || dat_v !== 32'h0 || ck_v !== 32'h4) begin
            n_fail++; $display("FAIL zero_seq: busy %h done %h dat %h ck %h expected 6 8 0 4", busy_v, done_v, dat_v, ck_v);
        end
        n_checks++;
        if (fill_num !== 24'd2 || burst_start_adr !== 23'd6) begin
            n_fail++; $display("FAIL zero_book: fill_num %0d adr %0d expected 2 6", fill_num, burst_start_adr);
        end
    endtask

    task automatic test_enable;
        enable = 1'b0;
        capture(21'd1, 4, 0, -1, 0);
        n_checks++;
        if (busy_v !== 32'h0 || wr_v !== 32'h0 || missed_trig !== 16'd0) begin
            n_fail++; $display("FAIL enable_low: busy %h wr %h missed %0d expected 0 0 0", busy_v, wr_v, missed_trig);
        end
        // Enable dropped mid-fill: the fill still completes.
        capture(21'd1, 10, 0, -1, 3);
        n_checks++;
        if (busy_v !== 32'h7E || done_v !== 32'h80 || wr_v !== 32'hC4) begin
            n_fail++; $display("FAIL enable_drop: busy %h done %h wr %h expected 7e 80 c4", busy_v, done_v, wr_v);
        end
        n_checks++;
        if (fill_num !== 24'd3 || burst_start_adr !== 23'd9) begin
            n_fail++; $display("FAIL enable_book: fill_num %0d adr %0d expected 3 9", fill_num, burst_start_adr);
        end
    endtask

    // Trigger held c=0..8: c=1..6 busy and c=7 (done) are missed, c=8 starts the next fill.
    task automatic test_back_to_back;
        capture(21'd1, 14, 8, -1, -1);
        n_checks++;
        if (busy_v !== 32'h3E7E) begin n_fail++; $display("FAIL b2b_busy: got %h expected %h", busy_v, 32'h3E7E); end
        n_checks++;
        if (wr_v !== 32'h04C4 || done_v !== 32'h80) begin
            n_fail++; $display("FAIL b2b_wr: wr %h done %h expected 4c4 80", wr_v, done_v);
        end
        n_checks++;
        if (missed_trig !== 16'd7) begin n_fail++; $display("FAIL b2b_missed: got %0d expected 7", missed_trig); end
        repeat (4) tick();
        n_checks++;
        if (fill_num !== 24'd5 || burst_start_adr !== 23'd15 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_book: fill_num %0d adr %0d busy %b expected 5 15 0", fill_num, burst_start_adr, busy);
        end
    endtask

    task automatic test_overflow;
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b expected 0", overflow); end
        capture(21'd2, 14, 0, 6, -1);
        n_checks++;
        if (wr_v !== 32'h0C04 || done_v !== 32'h0800) begin
            n_fail++; $display("FAIL ovf_wr: wr %h done %h expected c04 800", wr_v, done_v);
        end
        n_checks++;
        if (overflow !== 1'b1 || fill_num !== 24'd6 || burst_start_adr !== 23'd19) begin
            n_fail++; $display("FAIL ovf_sticky: ovf %b fill_num %0d adr %0d expected 1 6 19", overflow, fill_num, burst_start_adr);
        end
    endtask

    task automatic test_reset_mid;
        capture(21'd2, 4, 0, -1, -1);
        n_checks++;
        if (select_dat !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: sel_dat %b expected 1", select_dat); end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({select_dat, select_checksum, busy, fifo_wr_en, fill_done, overflow} !== 6'b0) begin
            n_fail++; $display("FAIL rmid_ctrl: got %b expected 000000",
                {select_dat, select_checksum, busy, fifo_wr_en, fill_done, overflow});
        end
        n_checks++;
        if ({fill_num, burst_start_adr, missed_trig, fill_type, num_fill_bursts} !== '0) begin
            n_fail++; $display("FAIL rmid_regs: fill_num %h adr %h missed %h type %h nb %h expected all 0",
                fill_num, burst_start_adr, missed_trig, fill_type, num_fill_bursts);
        end
        reset = 1'b0;
        capture(21'd1, 10, 0, -1, -1);
        n_checks++;
        if (wr_v !== 32'hC4 || busy_v !== 32'h7E) begin
            n_fail++; $display("FAIL rmid_fresh: wr %h busy %h expected c4 7e", wr_v, busy_v);
        end
        n_checks++;
        if (fill_num !== 24'd1 || burst_start_adr !== 23'd3) begin
            n_fail++; $display("FAIL rmid_book: fill_num %0d adr %0d expected 1 3", fill_num, burst_start_adr);
        end
    endtask

    task automatic fill2(input logic [2:0] n);
        num2 = n; trig2 = 1'b1;
        tick();
        trig2 = 1'b0;
        repeat (4 * int'(n) + 4) tick();
    endtask

    // 4-bit address: 5 + 5 + 4 = 14 (two below the top), then +5 wraps to 3.
    task automatic test_wrap;
        fill2(3'd3); fill2(3'd3); fill2(3'd2);
        n_checks++;
        if (adr2 !== 4'hE) begin n_fail++; $display("FAIL wrap_pre: adr %h expected e", adr2); end
        fill2(3'd3);
        n_checks++;
        if (adr2 !== 4'h3 || fn2 !== 24'd4) begin
            n_fail++; $display("FAIL wrap_adr: adr %h fill_num %0d expected 3 4", adr2, fn2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_bursts();
        test_enable();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
